// File: rtl/imm_gen_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Registered immediate generator with pc+imm target and a 2-entry
//            skid buffer between decode and execute.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN = 32,  // 32 or 64
  parameter int ILEN = 32   // fixed at 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [2:0]      in_sel,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [ILEN-1:0] out_instr
);

  localparam logic [2:0] c_SEL_R  = 3'b000;
  localparam logic [2:0] c_SEL_I  = 3'b001;
  localparam logic [2:0] c_SEL_B  = 3'b010;
  localparam logic [2:0] c_SEL_J1 = 3'b011;
  localparam logic [2:0] c_SEL_J2 = 3'b100;
  localparam logic [2:0] c_SEL_U  = 3'b101;
  localparam logic [2:0] c_SEL_Z  = 3'b110;
  localparam logic [2:0] c_SEL_S  = 3'b111;

  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_target;
  logic            w_in_fire;
  logic            w_main_free;

  logic            r_in_ready;
  logic            r_main_valid;
  logic [XLEN-1:0] r_main_imm;
  logic [XLEN-1:0] r_main_target;
  logic [ILEN-1:0] r_main_instr;
  logic            r_skid_valid;
  logic [XLEN-1:0] r_skid_imm;
  logic [XLEN-1:0] r_skid_target;
  logic [ILEN-1:0] r_skid_instr;

  // Every format fits in 32 bits with bit 31 equal to the sign (0 for Z/R),
  // so one signed widening covers both XLEN choices.
  always_comb begin
    w_imm32 = '0;
    case (in_sel)
      c_SEL_I, c_SEL_J2: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      c_SEL_S:  w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      c_SEL_B:  w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
      c_SEL_J1: w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
      c_SEL_U:  w_imm32 = {in_instr[31:12], 12'b0};
      c_SEL_Z:  w_imm32 = {27'b0, in_instr[19:15]};
      c_SEL_R:  w_imm32 = '0;
      default:  w_imm32 = '0;
    endcase
  end

  assign w_imm       = XLEN'($signed(w_imm32));
  assign w_target    = in_pc + w_imm;
  assign w_in_fire   = in_valid & r_in_ready;
  assign w_main_free = !r_main_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready    <= 1'b1;
      r_main_valid  <= 1'b0;
      r_main_imm    <= '0;
      r_main_target <= '0;
      r_main_instr  <= '0;
      r_skid_valid  <= 1'b0;
      r_skid_imm    <= '0;
      r_skid_target <= '0;
      r_skid_instr  <= '0;
    end else if (flush) begin
      r_in_ready   <= 1'b1;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      // Skid refills main first; the input is blocked while skid is full.
      if (r_skid_valid) begin
        r_main_valid  <= 1'b1;
        r_main_imm    <= r_skid_imm;
        r_main_target <= r_skid_target;
        r_main_instr  <= r_skid_instr;
        r_skid_valid  <= 1'b0;
        r_in_ready    <= 1'b1;
      end else if (w_in_fire) begin
        r_main_valid  <= 1'b1;
        r_main_imm    <= w_imm;
        r_main_target <= w_target;
        r_main_instr  <= in_instr;
      end else begin
        r_main_valid  <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_valid  <= 1'b1;
      r_skid_imm    <= w_imm;
      r_skid_target <= w_target;
      r_skid_instr  <= in_instr;
      r_in_ready    <= 1'b0;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_main_valid;
  assign out_imm    = r_main_imm;
  assign out_target = r_main_target;
  assign out_instr  = r_main_instr;

endmodule
`default_nettype wire
